neorv32_uart_boot_stub: RTL and testbench



---
 rtl/neorv32_uart_boot_stub.sv | 208 ++++++++++++++++++++
 tb/tb_neorv32_uart_boot_stub.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neorv32_uart_boot_stub.sv
// neorv32_uart_boot_stub: UART0 boot console stand-in.
// Sends a fixed "\r\nNEORV32\r\n" banner after reset, then echoes every valid received byte.
module neorv32_uart_boot_stub #(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic uart0_rxd_i,
  output logic uart0_txd_o
);

  localparam int unsigned BAUD_DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV  = BAUD_DIV / 2;
  localparam int unsigned HALF_LOAD = (HALF_DIV > 0) ? HALF_DIV - 1 : 0;
  localparam int unsigned CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W    = PTR_W + 1;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ROM_LAST  = 10;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_BANNER = 2'd1;
  localparam logic [1:0] ST_ECHO   = 2'd2;

  // Banner ROM: CR LF "NEORV32" CR LF
  function automatic logic [7:0] banner_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    banner_byte = 8'h0D;
      4'd1:    banner_byte = 8'h0A;
      4'd2:    banner_byte = 8'h4E;
      4'd3:    banner_byte = 8'h45;
      4'd4:    banner_byte = 8'h4F;
      4'd5:    banner_byte = 8'h52;
      4'd6:    banner_byte = 8'h56;
      4'd7:    banner_byte = 8'h33;
      4'd8:    banner_byte = 8'h32;
      4'd9:    banner_byte = 8'h0D;
      default: banner_byte = 8'h0A;
    endcase
  endfunction

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tx_load_c, pop_c, tx_ready_c;
  logic [7:0]       tx_byte_c;

  logic             tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bits;
  logic [8:0]       tx_shift;

  logic             rx_s1, rx_s2, rx_h, rx_busy, rx_block;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bits;
  logic [7:0]       rx_shift;
  logic             push_c, wr_en_c;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_empty_c, fifo_full_c;

  // TX can take a new byte when idle or on the last cycle of a stop bit (no gap between frames)
  assign tx_ready_c   = !tx_busy || ((tx_cnt == '0) && (tx_bits == '0));
  assign fifo_empty_c = (fifo_cnt == '0);
  assign fifo_full_c  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign push_c       = rx_busy && (rx_cnt == '0) && (rx_bits == 4'd9) && rx_s2;
  assign wr_en_c      = push_c && (!fifo_full_c || pop_c);

  // Boot FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_WAIT;
      wait_cnt <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      idx      <= idx_nxt;
    end
  end

  // Boot FSM next state: idle gap, banner bytes, then FIFO echo
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    idx_nxt   = idx;
    tx_load_c = 1'b0;
    tx_byte_c = 8'h00;
    pop_c     = 1'b0;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == CNT_W'(BAUD_DIV - 1)) state_nxt = ST_BANNER;
        else wait_nxt = wait_cnt + CNT_W'(1);
      end
      ST_BANNER: begin
        if (tx_ready_c) begin
          tx_load_c = 1'b1;
          tx_byte_c = banner_byte(idx);
          if (idx == IDX_W'(ROM_LAST)) state_nxt = ST_ECHO;
          else idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_ECHO: begin
        if (tx_ready_c && !fifo_empty_c) begin
          tx_load_c = 1'b1;
          tx_byte_c = fifo_mem[rd_ptr];
          pop_c     = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  // 8N1 transmitter; start bit is driven on the load edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      uart0_txd_o <= 1'b1;
      tx_busy     <= 1'b0;
      tx_cnt      <= '0;
      tx_bits     <= '0;
      tx_shift    <= '1;
    end else if (tx_load_c) begin
      uart0_txd_o <= 1'b0;
      tx_busy     <= 1'b1;
      tx_cnt      <= CNT_W'(BAUD_DIV - 1);
      tx_bits     <= 4'd9;
      tx_shift    <= {1'b1, tx_byte_c};
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CNT_W'(1);
      end else if (tx_bits == '0) begin
        tx_busy <= 1'b0;
      end else begin
        uart0_txd_o <= tx_shift[0];
        tx_shift    <= {1'b1, tx_shift[8:1]};
        tx_bits     <= tx_bits - 4'd1;
        tx_cnt      <= CNT_W'(BAUD_DIV - 1);
      end
    end
  end

  // Receiver: synchronizer, mid-bit sampling, false-start and framing-error rejection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_h     <= 1'b1;
      rx_busy  <= 1'b0;
      rx_block <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= uart0_rxd_i;
      rx_s2 <= rx_s1;
      rx_h  <= rx_s2;
      if (!rx_busy) begin
        if (rx_block) begin
          if (rx_s2) rx_block <= 1'b0;
        end else if (rx_h && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CNT_W'(HALF_LOAD);
          rx_bits <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CNT_W'(1);
      end else begin
        rx_cnt <= CNT_W'(BAUD_DIV - 1);
        if (rx_bits == '0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else rx_bits <= 4'd1;
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          if (!rx_s2) rx_block <= 1'b1;
        end else begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bits  <= rx_bits + 4'd1;
        end
      end
    end
  end

  // Echo FIFO; a push while full is only accepted together with a pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      if (wr_en_c) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_neorv32_uart_boot_stub.sv
// Bench for neorv32_uart_boot_stub, run at a scaled baud rate (16 clocks per bit).
module tb_neorv32_uart_boot_stub;

  localparam int unsigned CLK_HZ = 100000000;
  localparam int unsigned BAUD   = 6250000;
  localparam int BD = int'(CLK_HZ / BAUD);

  logic clk_i = 1'b0;
  logic rstn_i;
  logic uart0_rxd_i;
  logic uart0_txd_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_errs = 0;
  logic [7:0] q_data[$];
  int q_time[$];
  logic [7:0] banner [11];

  neorv32_uart_boot_stub #(
    .CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .uart0_rxd_i(uart0_rxd_i),
    .uart0_txd_o(uart0_txd_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Decode txd into bytes with the cycle of each start bit; frames cut by reset are dropped
  initial begin : tx_monitor
    logic [7:0] b;
    logic abort;
    int t0;
    int n;
    forever begin
      @(negedge clk_i);
      if (rstn_i === 1'b1 && uart0_txd_o === 1'b0) begin
        t0 = cyc;
        abort = 1'b0;
        b = 8'h00;
        for (int k = 0; k < 10; k++) begin
          n = (k == 0) ? BD / 2 : BD;
          for (int j = 0; j < n; j++) begin
            @(negedge clk_i);
            if (rstn_i !== 1'b1) begin
              abort = 1'b1;
              break;
            end
          end
          if (abort) break;
          if (k >= 1 && k <= 8) b = {uart0_txd_o, b[7:1]};
          if (k == 9 && uart0_txd_o !== 1'b1) stop_errs++;
        end
        if (!abort) begin
          q_data.push_back(b);
          q_time.push_back(t0);
        end
      end
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_time.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int i;
    i = 0;
    while (q_data.size() < n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    ok = (q_data.size() >= n);
  endtask

  task automatic wait_level(input logic v, input int budget, output bit ok, output int t);
    int i;
    i = 0;
    while (uart0_txd_o !== v && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    ok = (uart0_txd_o === v);
    t = cyc;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart0_rxd_i = f[k];
      repeat (BD) @(negedge clk_i);
    end
  endtask

  task automatic do_reset(output int rel);
    @(negedge clk_i);
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    rel = cyc;
    clear_q();
  endtask

  task automatic test_reset(output int rel);
    rstn_i = 1'b0;
    uart0_rxd_i = 1'b0;
    repeat (10) @(negedge clk_i);
    total++;
    if (uart0_txd_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_txd: got %b want 1", uart0_txd_o);
    end
    rstn_i = 1'b1;
    rel = cyc;
    clear_q();
    repeat (BD - 4) @(negedge clk_i);
    total++;
    if (uart0_txd_o !== 1'b1) begin
      bad++;
      $display("FAIL wait_idle_txd: got %b want 1", uart0_txd_o);
    end
  endtask

  // Banner with rxd held low: start timing, bit edges of CR, content, contiguity, silence after
  task automatic test_banner(input int rel);
    int offs [6];
    int t_fall, t;
    bit ok;
    logic [7:0] got;
    offs = '{16, 32, 48, 80, 144, 160};
    wait_level(1'b0, 3 * BD, ok, t_fall);
    total++;
    if (!ok || t_fall - rel < BD - 2 || t_fall - rel > BD + 2) begin
      bad++;
      $display("FAIL first_start: got delay %0d ok=%0b want %0d..%0d", t_fall - rel, ok, BD - 2, BD + 2);
    end
    for (int i = 0; i < 6; i++) begin
      wait_level((i % 2) == 0 ? 1'b1 : 1'b0, 100, ok, t);
      total++;
      if (!ok || t - t_fall != offs[i]) begin
        bad++;
        $display("FAIL cr_edge[%0d]: got offset %0d ok=%0b want %0d", i, t - t_fall, ok, offs[i]);
      end
    end
    wait_bytes(11, 12 * 10 * BD, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL banner_len: got %0d bytes want 11", q_data.size());
    end
    for (int i = 0; i < 11; i++) begin
      got = (i < q_data.size()) ? q_data[i] : 8'hxx;
      total++;
      if (got !== banner[i]) begin
        bad++;
        $display("FAIL banner_byte[%0d]: got %02h want %02h", i, got, banner[i]);
      end
    end
    for (int i = 1; i < 11 && i < q_time.size(); i++) begin
      total++;
      if (q_time[i] - q_time[i-1] != 10 * BD) begin
        bad++;
        $display("FAIL banner_gap[%0d]: got %0d want %0d", i, q_time[i] - q_time[i-1], 10 * BD);
      end
    end
    if (q_time.size() > 8) begin
      total++;
      if (q_time[8] + 10 * BD - rel > 91 * BD + 2) begin
        bad++;
        $display("FAIL neorv32_done: got %0d cycles want <= %0d", q_time[8] + 10 * BD - rel, 91 * BD + 2);
      end
    end
    repeat (30 * BD) @(negedge clk_i);
    total++;
    if (q_data.size() != 11) begin
      bad++;
      $display("FAIL quiet_after_banner: got %0d bytes want 11", q_data.size());
    end
    total++;
    if (stop_errs != 0) begin
      bad++;
      $display("FAIL tx_stop_bits: got %0d bad stop bits want 0", stop_errs);
    end
  endtask

  task automatic test_echo();
    bit ok;
    uart0_rxd_i = 1'b1;
    repeat (4 * BD) @(negedge clk_i);
    clear_q();
    send_frame(8'h41, 1'b1);
    send_frame(8'h7A, 1'b1);
    wait_bytes(2, 40 * BD, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL echo_count: got %0d bytes want 2", q_data.size());
    end
    total++;
    if (q_data.size() < 1 || q_data[0] !== 8'h41) begin
      bad++;
      $display("FAIL echo_byte0: got %02h want 41", q_data.size() > 0 ? q_data[0] : 8'hxx);
    end
    total++;
    if (q_data.size() < 2 || q_data[1] !== 8'h7A) begin
      bad++;
      $display("FAIL echo_byte1: got %02h want 7a", q_data.size() > 1 ? q_data[1] : 8'hxx);
    end
  endtask

  task automatic test_framing();
    bit ok;
    clear_q();
    send_frame(8'h55, 1'b0);
    uart0_rxd_i = 1'b1;
    repeat (2 * BD) @(negedge clk_i);
    send_frame(8'h33, 1'b1);
    wait_bytes(1, 30 * BD, ok);
    repeat (20 * BD) @(negedge clk_i);
    total++;
    if (q_data.size() != 1) begin
      bad++;
      $display("FAIL framing_count: got %0d bytes want 1", q_data.size());
    end
    total++;
    if (q_data.size() < 1 || q_data[0] !== 8'h33) begin
      bad++;
      $display("FAIL framing_byte: got %02h want 33", q_data.size() > 0 ? q_data[0] : 8'hxx);
    end
  endtask

  // Six bytes arrive while the banner is still going, so nothing is popped before the last push
  task automatic test_fifo_overflow();
    logic [7:0] d [6];
    logic [7:0] exp_q [4];
    logic [7:0] got;
    int mcnt, rel;
    bit ok;
    d = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h80, 8'h7F};
    mcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mcnt < 4) begin
        exp_q[mcnt] = d[i];
        mcnt++;
      end
    end
    uart0_rxd_i = 1'b1;
    do_reset(rel);
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 6; i++) send_frame(d[i], 1'b1);
    wait_bytes(11 + mcnt, 20 * 10 * BD, ok);
    repeat (30 * BD) @(negedge clk_i);
    total++;
    if (q_data.size() != 11 + mcnt) begin
      bad++;
      $display("FAIL overflow_count: got %0d bytes want %0d", q_data.size(), 11 + mcnt);
    end
    for (int i = 0; i < mcnt; i++) begin
      got = (11 + i < q_data.size()) ? q_data[11 + i] : 8'hxx;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL overflow_byte[%0d]: got %02h want %02h", i, got, exp_q[i]);
      end
    end
    if (q_time.size() > 11) begin
      total++;
      if (q_time[11] - q_time[10] != 10 * BD) begin
        bad++;
        $display("FAIL banner_to_echo_gap: got %0d want %0d", q_time[11] - q_time[10], 10 * BD);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int rel, t;
    bit ok;
    logic [7:0] got;
    do_reset(rel);
    wait_bytes(4, 6 * 10 * BD, ok);
    wait_level(1'b0, 2 * BD, ok, t);
    @(negedge clk_i);
    total++;
    if (uart0_txd_o !== 1'b0) begin
      bad++;
      $display("FAIL o_start_bit: got %b want 0", uart0_txd_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    total++;
    if (uart0_txd_o !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_txd: got %b want 1", uart0_txd_o);
    end
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    rel = cyc;
    clear_q();
    wait_bytes(11, 12 * 10 * BD, ok);
    total++;
    if (q_time.size() < 1 || q_time[0] - rel < BD - 2 || q_time[0] - rel > BD + 2) begin
      bad++;
      $display("FAIL restart_start: got delay %0d want %0d..%0d", q_time.size() > 0 ? q_time[0] - rel : -1, BD - 2, BD + 2);
    end
    for (int i = 0; i < 11; i++) begin
      got = (i < q_data.size()) ? q_data[i] : 8'hxx;
      total++;
      if (got !== banner[i]) begin
        bad++;
        $display("FAIL restart_byte[%0d]: got %02h want %02h", i, got, banner[i]);
      end
    end
  endtask

  initial begin : main
    int rel;
    banner = '{8'h0D, 8'h0A, 8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32, 8'h0D, 8'h0A};
    rstn_i = 1'b0;
    uart0_rxd_i = 1'b0;
    test_reset(rel);
    test_banner(rel);
    test_echo();
    test_framing();
    test_fifo_overflow();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
